axis_traffic_gen: RTL and testbench

AXIS_TRAFFIC_GEN -- requirements
Module: axis_traffic_gen

---
 rtl/axis_traffic_gen_pkg.sv | 42 ++++
 rtl/lfsr_gen.sv | 23 ++
 rtl/axis_traffic_gen.sv | 157 +++++++++++++++
 tb/tb_axis_traffic_gen.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/axis_traffic_gen_pkg.sv
// Shared types and constants for the AXI-Stream traffic generator:
// FSM states, payload modes and the LFSR tap table.
package axis_traffic_gen_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT_RX,
      FIN
   } state_t;

   localparam int DATA_MODE_LFSR = 0;
   localparam int DATA_MODE_CNT  = 1;

   // Width of the packet, beat, destination and RX counters
   localparam int CNT_W = 16;

   // Feedback tap mask per LFSR width (bit i set = state bit i feeds back)
   function automatic logic [31:0] lfsr_taps(input int w);
      case (w)
         3:       return 32'h0000_0006;
         4:       return 32'h0000_000C;
         5:       return 32'h0000_0014;
         6:       return 32'h0000_0030;
         7:       return 32'h0000_0060;
         8:       return 32'h0000_00B8;
         16:      return 32'h0000_B400;
         32:      return 32'h8020_0003;
         default: return 32'h0000_0003 << (w - 2);
      endcase
   endfunction

   // One left shift of a w-bit Fibonacci LFSR, feedback into bit 0
   function automatic logic [31:0] lfsr_step(input logic [31:0] s, input int w);
      logic [31:0] mask;
      logic        fb;
      mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
      fb   = ^(s & lfsr_taps(w));
      return ((s << 1) | {31'b0, fb}) & mask;
   endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Payload LFSR: holds its state across runs and advances one step per
// enabled cycle; only reset returns it to the seed.
module lfsr_gen
   import axis_traffic_gen_pkg::*;
#(
   parameter int           W    = 8,
   parameter logic [W-1:0] SEED = 'h01
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         adv,
   output logic [W-1:0] state
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SEED;
      end else if (adv) begin
         state <= W'(lfsr_step(32'(state), W));
      end
   end

endmodule

// File: rtl/axis_traffic_gen.sv
// AXI-Stream traffic generator: on START sends NUM_PACKETS packets of PKT_LEN
// beats, then waits for EXPECT_RX received packets before raising DONE.
module axis_traffic_gen
   import axis_traffic_gen_pkg::*;
#(
   parameter int                 TDATAW       = 32,
   parameter int                 TDESTW       = 4,
   parameter int                 LFSR_DW      = 8,
   parameter logic [LFSR_DW-1:0] LFSR_DEFAULT = 8'h01,
   parameter int                 NUM_PACKETS  = 5,
   parameter int                 PKT_LEN      = 4,
   parameter int                 DEST_FIRST   = 1,
   parameter int                 NUM_DEST     = 1,
   parameter int                 DATA_MODE    = DATA_MODE_LFSR,
   parameter int                 EXPECT_RX    = 0
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              START,
   output logic              DONE,
   output logic              AXIS_M_TVALID,
   input  logic              AXIS_M_TREADY,
   output logic [TDATAW-1:0] AXIS_M_TDATA,
   output logic              AXIS_M_TLAST,
   output logic [TDESTW-1:0] AXIS_M_TDEST,
   input  logic              AXIS_S_TVALID,
   output logic              AXIS_S_TREADY,
   input  logic [TDATAW-1:0] AXIS_S_TDATA,
   input  logic              AXIS_S_TLAST,
   input  logic [TDESTW-1:0] AXIS_S_TDEST
);

   if (LFSR_DW > TDATAW || LFSR_DW > 32) begin : g_bad_lfsr_w
      $error("LFSR_DW must not exceed TDATAW (or 32)");
   end
   if (LFSR_DEFAULT == '0) begin : g_bad_seed
      $error("LFSR_DEFAULT must be nonzero");
   end
   if (PKT_LEN < 1) begin : g_bad_pkt_len
      $error("PKT_LEN must be at least 1");
   end
   if (NUM_DEST < 1) begin : g_bad_num_dest
      $error("NUM_DEST must be at least 1");
   end

   state_t             state, state_nx;
   logic [LFSR_DW-1:0] lfsr_state, lfsr_nx;
   logic [CNT_W-1:0]   beat_cnt, pkt_cnt, dest_idx, dest_idx_nx, rx_cnt, rx_inc;
   logic               start_acc, accept, last_beat, last_pkt, rx_last, lfsr_adv;
   logic               rx_unused;

   function automatic logic [TDESTW-1:0] dest_of(input logic [CNT_W-1:0] idx);
      logic [31:0] sum;
      sum = 32'(DEST_FIRST) + 32'(idx);
      return sum[TDESTW-1:0];
   endfunction

   // The receive side only counts TLAST beats; payload and dest are not inspected
   assign AXIS_S_TREADY = RST_N;
   assign rx_unused     = ^{AXIS_S_TDATA, AXIS_S_TDEST};
   assign rx_last       = AXIS_S_TVALID && AXIS_S_TREADY && AXIS_S_TLAST;
   assign rx_inc        = (rx_last && rx_cnt != '1) ? rx_cnt + CNT_W'(1) : rx_cnt;

   assign start_acc   = START && (state == IDLE || state == FIN);
   assign accept      = (state == SEND) && AXIS_M_TVALID && AXIS_M_TREADY;
   assign last_beat   = (beat_cnt == CNT_W'(PKT_LEN - 1));
   assign last_pkt    = (pkt_cnt == CNT_W'(NUM_PACKETS - 1));
   assign dest_idx_nx = (dest_idx == CNT_W'(NUM_DEST - 1)) ? '0 : dest_idx + CNT_W'(1);
   assign lfsr_adv    = accept && (DATA_MODE == DATA_MODE_LFSR);
   assign lfsr_nx     = LFSR_DW'(lfsr_step(32'(lfsr_state), LFSR_DW));

   lfsr_gen #(
      .W    (LFSR_DW),
      .SEED (LFSR_DEFAULT)
   ) u_lfsr (
      .clk   (CLK),
      .rst_n (RST_N),
      .adv   (lfsr_adv),
      .state (lfsr_state)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // WAIT_RX looks at the count including a TLAST beat arriving this cycle
   always_comb begin
      state_nx = state;
      case (state)
         IDLE, FIN: begin
            if (START) begin
               state_nx = (NUM_PACKETS == 0) ? WAIT_RX : SEND;
            end
         end
         SEND: begin
            if (accept && last_beat && last_pkt) begin
               state_nx = WAIT_RX;
            end
         end
         WAIT_RX: begin
            if (rx_inc >= CNT_W'(EXPECT_RX)) begin
               state_nx = FIN;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rx_cnt        <= '0;
         beat_cnt      <= '0;
         pkt_cnt       <= '0;
         dest_idx      <= '0;
         DONE          <= 1'b0;
         AXIS_M_TVALID <= 1'b0;
         AXIS_M_TLAST  <= 1'b0;
         AXIS_M_TDATA  <= '0;
         AXIS_M_TDEST  <= '0;
      end else begin
         DONE   <= (state_nx == FIN);
         rx_cnt <= start_acc ? CNT_W'(rx_last) : rx_inc;
         if (start_acc) begin
            beat_cnt      <= '0;
            pkt_cnt       <= '0;
            dest_idx      <= '0;
            AXIS_M_TVALID <= (NUM_PACKETS != 0);
            AXIS_M_TLAST  <= (PKT_LEN == 1);
            AXIS_M_TDEST  <= dest_of('0);
            AXIS_M_TDATA  <= (DATA_MODE == DATA_MODE_CNT) ? '0 : TDATAW'(lfsr_state);
         end else if (accept) begin
            if (last_beat && last_pkt) begin
               AXIS_M_TVALID <= 1'b0;
               AXIS_M_TLAST  <= 1'b0;
            end else begin
               if (last_beat) begin
                  beat_cnt     <= '0;
                  pkt_cnt      <= pkt_cnt + CNT_W'(1);
                  dest_idx     <= dest_idx_nx;
                  AXIS_M_TLAST <= (PKT_LEN == 1);
                  AXIS_M_TDEST <= dest_of(dest_idx_nx);
               end else begin
                  beat_cnt     <= beat_cnt + CNT_W'(1);
                  AXIS_M_TLAST <= (beat_cnt + CNT_W'(1) == CNT_W'(PKT_LEN - 1));
               end
               AXIS_M_TDATA <= (DATA_MODE == DATA_MODE_CNT) ? AXIS_M_TDATA + TDATAW'(1)
                                                           : TDATAW'(lfsr_nx);
            end
         end
      end
   end

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Directed bench: default-config generator (LFSR payload) plus a counter-payload,
// round-robin, EXPECT_RX=2 instance.
`timescale 1ns/1ps
module tb_axis_traffic_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // default instance
   logic        rst0_n, start0, tready0, s0_tvalid, s0_tlast;
   logic [31:0] s0_tdata;
   logic [3:0]  s0_tdest;
   logic        done0, m_tvalid0, m_tlast0, s_tready0;
   logic [31:0] m_tdata0;
   logic [3:0]  m_tdest0;

   // counter-payload, 3 destinations, single-beat packets, EXPECT_RX=2
   logic        rst1_n, start1, tready1, s1_tvalid, s1_tlast;
   logic [31:0] s1_tdata;
   logic [3:0]  s1_tdest;
   logic        done1, m_tvalid1, m_tlast1, s_tready1;
   logic [31:0] m_tdata1;
   logic [3:0]  m_tdest1;

   logic [7:0] exp_lfsr;
   logic [3:0] dtab [5] = '{4'd2, 4'd3, 4'd4, 4'd2, 4'd3};

   axis_traffic_gen u_dut0 (
      .CLK(clk), .RST_N(rst0_n), .START(start0), .DONE(done0),
      .AXIS_M_TVALID(m_tvalid0), .AXIS_M_TREADY(tready0), .AXIS_M_TDATA(m_tdata0),
      .AXIS_M_TLAST(m_tlast0), .AXIS_M_TDEST(m_tdest0),
      .AXIS_S_TVALID(s0_tvalid), .AXIS_S_TREADY(s_tready0), .AXIS_S_TDATA(s0_tdata),
      .AXIS_S_TLAST(s0_tlast), .AXIS_S_TDEST(s0_tdest)
   );

   axis_traffic_gen #(
      .NUM_PACKETS(5), .PKT_LEN(1), .DEST_FIRST(2), .NUM_DEST(3),
      .DATA_MODE(1), .EXPECT_RX(2)
   ) u_dut1 (
      .CLK(clk), .RST_N(rst1_n), .START(start1), .DONE(done1),
      .AXIS_M_TVALID(m_tvalid1), .AXIS_M_TREADY(tready1), .AXIS_M_TDATA(m_tdata1),
      .AXIS_M_TLAST(m_tlast1), .AXIS_M_TDEST(m_tdest1),
      .AXIS_S_TVALID(s1_tvalid), .AXIS_S_TREADY(s_tready1), .AXIS_S_TDATA(s1_tdata),
      .AXIS_S_TLAST(s1_tlast), .AXIS_S_TDEST(s1_tdest)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [7:0] step8(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   // Drive one full default run from the first beat on the bus; called at a negedge.
   task automatic run0(input int stall_beat, input int start_beat, input bit chk_first);
      int          beats = 0;
      int          cyc   = 0;
      int          stall = 0;
      bit          start_sent = 0;
      logic [31:0] held_d = '0;
      logic        held_l = 1'b0;
      logic [7:0]  first5 [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
      while (beats < 20 && cyc < 300) begin
         start0  = (beats == start_beat) && !start_sent;
         if (start0) start_sent = 1;
         tready0 = !(beats == stall_beat && stall < 3);
         chk("tvalid_no_bubble", m_tvalid0, 1'b1);
         if (!tready0) begin
            if (stall == 0) begin
               held_d = m_tdata0;
               held_l = m_tlast0;
            end else begin
               chk("stall_tdata", m_tdata0, held_d);
               chk("stall_tlast", m_tlast0, held_l);
            end
            stall++;
         end else begin
            chk("beat_tdata", m_tdata0, {24'b0, exp_lfsr});
            chk("beat_tlast", m_tlast0, (beats % 4) == 3);
            chk("beat_tdest", m_tdest0, 4'd1);
            if (chk_first && beats < 5) chk("first_tdata", m_tdata0, {24'b0, first5[beats]});
            exp_lfsr = step8(exp_lfsr);
            beats++;
         end
         @(negedge clk);
         cyc++;
      end
      start0  = 1'b0;
      tready0 = 1'b1;
      chk("run_beat_count", beats, 20);
      chk("tvalid_drop", m_tvalid0, 1'b0);
      chk("done_wait_rx", done0, 1'b0);
      @(negedge clk);
      chk("done_rise", done0, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst0_n = 1'b0; rst1_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
      tready0 = 1'b1; tready1 = 1'b1;
      s0_tvalid = 1'b0; s0_tlast = 1'b0; s0_tdata = '0; s0_tdest = '0;
      s1_tvalid = 1'b0; s1_tlast = 1'b0; s1_tdata = '0; s1_tdest = '0;
      exp_lfsr = 8'h01;
      repeat (3) @(negedge clk);
      chk("rst_tvalid", m_tvalid0, 1'b0);
      chk("rst_tlast", m_tlast0, 1'b0);
      chk("rst_tdata", m_tdata0, 32'h0);
      chk("rst_tdest", m_tdest0, 4'h0);
      chk("rst_done", done0, 1'b0);
      chk("rst_s_tready", s_tready0, 1'b0);
      rst0_n = 1'b1; rst1_n = 1'b1;
      @(negedge clk);
      chk("s_tready_up", s_tready0, 1'b1);
      chk("idle_tvalid", m_tvalid0, 1'b0);

      // Run 1: plain run with a stray START during SEND
      start0 = 1'b1; @(negedge clk); start0 = 1'b0;
      chk("tvalid_latency", m_tvalid0, 1'b1);
      run0(-1, 6, 1'b1);

      // Run 2: restart from FIN, LFSR continues; 3-cycle stall mid-packet
      start0 = 1'b1; @(negedge clk); start0 = 1'b0;
      chk("done_clear", done0, 1'b0);
      chk("tvalid_latency2", m_tvalid0, 1'b1);
      chk("lfsr_continue", m_tdata0, {24'b0, exp_lfsr});
      run0(5, -1, 1'b0);

      // Run 3: reset while beat 2 is on the bus
      start0 = 1'b1; @(negedge clk); start0 = 1'b0;
      repeat (2) @(negedge clk);
      chk("beat2_on_bus", m_tdata0, {24'b0, step8(step8(exp_lfsr))});
      #2 rst0_n = 1'b0;
      #1;
      chk("rst_async_tvalid", m_tvalid0, 1'b0);
      chk("rst_async_tdata", m_tdata0, 32'h0);
      chk("rst_async_s_tready", s_tready0, 1'b0);
      @(negedge clk); @(negedge clk);
      rst0_n = 1'b1;
      exp_lfsr = 8'h01;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("post_rst_tvalid", m_tvalid0, 1'b0);
         chk("post_rst_done", done0, 1'b0);
      end
      start0 = 1'b1; @(negedge clk); start0 = 1'b0;
      chk("tvalid_latency3", m_tvalid0, 1'b1);
      run0(-1, -1, 1'b1);

      // Counter payload, round-robin destinations, EXPECT_RX=2
      start1 = 1'b1; @(negedge clk); start1 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("rr_tvalid", m_tvalid1, 1'b1);
         chk("rr_tdata", m_tdata1, i);
         chk("rr_tdest", m_tdest1, dtab[i]);
         chk("rr_tlast", m_tlast1, 1'b1);
         @(negedge clk);
      end
      chk("rr_tvalid_drop", m_tvalid1, 1'b0);
      repeat (3) begin
         chk("rx_wait_done", done1, 1'b0);
         @(negedge clk);
      end
      s1_tvalid = 1'b1; s1_tlast = 1'b1; @(negedge clk); s1_tvalid = 1'b0; s1_tlast = 1'b0;
      for (int i = 0; i < 9; i++) begin
         chk("rx_one_done", done1, 1'b0);
         @(negedge clk);
      end
      s1_tvalid = 1'b1; s1_tlast = 1'b1; @(negedge clk); s1_tvalid = 1'b0; s1_tlast = 1'b0;
      chk("rx_two_done", done1, 1'b1);
      s1_tvalid = 1'b1; s1_tlast = 1'b1; @(negedge clk); s1_tvalid = 1'b0; s1_tlast = 1'b0;
      chk("fin_rx_done", done1, 1'b1);

      // START coinciding with an RX TLAST: RX count restarts at 1
      start1 = 1'b1; s1_tvalid = 1'b1; s1_tlast = 1'b1;
      @(negedge clk);
      start1 = 1'b0; s1_tvalid = 1'b0; s1_tlast = 1'b0;
      chk("restart_done_clear", done1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk("rr2_tdata", m_tdata1, i);
         chk("rr2_tdest", m_tdest1, dtab[i]);
         @(negedge clk);
      end
      chk("rr2_tvalid_drop", m_tvalid1, 1'b0);
      @(negedge clk);
      chk("rx_load1_wait", done1, 1'b0);
      s1_tvalid = 1'b1; s1_tlast = 1'b1; @(negedge clk); s1_tvalid = 1'b0; s1_tlast = 1'b0;
      chk("rx_load1_done", done1, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
